z80_prefetch_biu: RTL and testbench
===================================

// Module: z80_prefetch_biu
// PURPOSE
//  Parametrised bus interface unit for the Z80 core family: owns the single memory port (A/DI/DO/W).
//  Prefetches opcode bytes into a DEPTH-entry queue and serves one data read/write at a time.
//  Data accesses take priority over prefetch. Memory read latency is configurable.
//  Sits between the decode/execute core and BRAM, replacing the core's ad-hoc pc+1 / latency counting.
// PARAMETERS
//  AW        16   address width; all address arithmetic wraps mod 2^AW
//  DEPTH     4    opcode queue entries; power of 2, >= 2
//  MEM_LAT   1    read latency in cycles (1..4): address in cycle k, DI valid in cycle k+MEM_LAT
//  RESET_PC  0    fetch address after reset
// PORTS
//  CLOCK     in   1   single clock, all state on rising edge
//  RESET     in   1   synchronous, active-high
//  A         out  AW  memory address (registered)
//  DI        in   8   memory read data
//  DO        out  8   memory write data (registered)
//  W         out  1   write strobe, one cycle per write (registered)
//  JUMP      in   1   redirect fetch stream; JUMP_PC is sampled with it
//  JUMP_PC   in   AW  new fetch address
//  OP_VALID  out  1   queue head valid
//  OP_DATA   out  8   opcode byte at queue head
//  OP_PC     out  AW  address of OP_DATA
//  OP_POP    in   1   consume head; ignored when OP_VALID=0
//  D_REQ     in   1   data access request; accepted at an edge where D_BUSY=0
//  D_WE      in   1   1 = write, 0 = read
//  D_ADDR    in   AW  data address
//  D_WDATA   in   8   write data
//  D_BUSY    out  1   data access accepted, not yet acked
//  D_ACK     out  1   one-cycle completion pulse
//  D_RDATA   out  8   read data; valid when D_ACK=1 for a read
// BEHAVIOUR
//  Reset:
//   - RESET=1 at an edge: queue empty, in-flight tracking cleared, fetch_pc=RESET_PC.
//   - A=RESET_PC, W=0, DO=0; OP_VALID=0, D_BUSY=0, D_ACK=0, D_RDATA=0.
//   - Reset mid-access drops the access; no D_ACK follows.
//  Bus issue (one slot per cycle, decided at each edge, applied to the next cycle):
//   1. Accepted data access not yet issued: A=D_ADDR; on write also W=1, DO=D_WDATA.
//   2. Otherwise, if count + inflight_fetches < DEPTH: fetch. A=fetch_pc, then fetch_pc+1 (wraps).
//   3. Otherwise idle: W=0, A holds.
//  In-flight tracking:
//   - MEM_LAT-stage shift pipe of {valid, is_fetch, pc}.
//   - At the edge ending cycle k+MEM_LAT, DI is sampled for the access issued in cycle k.
//   - Sampled fetch with valid=1 is pushed {DI,pc} into the queue; never overflows (credit rule above).
//  Data port:
//   - Accepted request is issued in the next cycle, bypassing pending fetches.
//   - Write: D_ACK pulses in the cycle after the W=1 cycle.
//   - Read: D_RDATA <= DI at the sampling edge; D_ACK pulses in the following cycle.
//   - D_BUSY=1 from the cycle after acceptance through the cycle before D_ACK.
//   - D_BUSY=0 in the D_ACK cycle, so back-to-back requests are allowed.
//   - Data writes are not snooped against queued opcodes. Self-modifying code must JUMP to resync.
//  Queue:
//   - OP_VALID = (count != 0).
//   - Push and pop at the same edge: count unchanged.
//   - Pop on empty is ignored.
//   - Head and tail pointers wrap mod DEPTH.
//  JUMP sampled high at edge J:
//   - Queue flushed and all in-flight fetch entries invalidated, including one issued in the cycle before J.
//   - fetch_pc=JUMP_PC. OP_POP at the same edge is ignored.
//   - In-flight data accesses are unaffected.
//   - The cycle after J fetches JUMP_PC unless a data access is pending.
//   - With MEM_LAT=1, first OP_VALID is in the cycle after edge J+2.
//  JUMP and D_REQ at the same edge: both take effect, and the data access issues first.
// TESTING
//  1. Reset, MEM_LAT=1, DEPTH=4, mem[i]=i, no pops -> A=0,1,2,3; OP_VALID after edge 2; fetching stalls at 4 queued; OP_PC=0, OP_DATA=0.
//  2. Pop every cycle from reset -> OP_DATA 00,01,02,... with no gaps once primed; A increments once per cycle.
//  3. Queue full at pc 4, D_REQ read D_ADDR=0x8000 (mem=0x5A) -> A=0x8000 in the next cycle; D_ACK with D_RDATA=0x5A two cycles later; queue intact.
//  4. D_REQ write 0x1234<-0xC3 while fetching -> exactly one cycle W=1, A=0x1234, DO=0xC3; D_ACK next cycle; a second request is accepted in the D_ACK cycle.
//  5. JUMP JUMP_PC=0xFFFE with 2 fetches in flight (MEM_LAT=3) -> stale bytes discarded; OP_PC sequence FFFE, FFFF, 0000 (wrap).
//  6. RESET asserted during an outstanding read -> no D_ACK; next cycle A=RESET_PC, OP_VALID=0.

Source files
------------

// File: rtl/z80_prefetch_biu.sv
// Bus interface unit for the Z80 core: owns the single memory port, prefetches
// opcode bytes into a small queue and serves one data read/write at a time.
module z80_prefetch_biu #(
    parameter int              AW       = 16,
    parameter int              DEPTH    = 4,
    parameter int              MEM_LAT  = 1,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          CLOCK,
    input  logic          RESET,
    output logic [AW-1:0] A,
    input  logic [7:0]    DI,
    output logic [7:0]    DO,
    output logic          W,
    input  logic          JUMP,
    input  logic [AW-1:0] JUMP_PC,
    output logic          OP_VALID,
    output logic [7:0]    OP_DATA,
    output logic [AW-1:0] OP_PC,
    input  logic          OP_POP,
    input  logic          D_REQ,
    input  logic          D_WE,
    input  logic [AW-1:0] D_ADDR,
    input  logic [7:0]    D_WDATA,
    output logic          D_BUSY,
    output logic          D_ACK,
    output logic [7:0]    D_RDATA
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] a_q;
    logic [7:0]    do_q;
    logic          w_q;
    logic [AW-1:0] fetch_pc_q;
    logic [AW-1:0] fetch_src;

    // Issue register: describes the access currently presented on A.
    logic          iss_v_q;
    logic          iss_f_q;
    logic          iss_we_q;
    logic [AW-1:0] iss_pc_q;

    logic [MEM_LAT-1:0]         pipe_v_q;
    logic [MEM_LAT-1:0]         pipe_f_q;
    logic [MEM_LAT-1:0][AW-1:0] pipe_pc_q;
    logic [MEM_LAT-1:0]         pipe_v_d;
    logic [MEM_LAT-1:0]         pipe_f_d;
    logic [MEM_LAT-1:0][AW-1:0] pipe_pc_d;

    logic [7:0]    q_data_mem [DEPTH];
    logic [AW-1:0] q_pc_mem   [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic          d_busy_q;
    logic          d_ack_q;
    logic [7:0]    d_rdata_q;

    logic          accept;
    logic          credit;
    logic          push;
    logic          pop;
    logic          tail_fetch;
    logic          tail_read;
    int            inflight;

    // A jump kills every fetch still travelling through the pipe; data reads survive.
    genvar gi;
    generate
        for (gi = 0; gi < MEM_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_first
                assign pipe_v_d[gi]  = iss_v_q && !iss_we_q && !(JUMP && iss_f_q);
                assign pipe_f_d[gi]  = iss_f_q;
                assign pipe_pc_d[gi] = iss_pc_q;
            end else begin : g_next
                assign pipe_v_d[gi]  = pipe_v_q[gi-1] && !(JUMP && pipe_f_q[gi-1]);
                assign pipe_f_d[gi]  = pipe_f_q[gi-1];
                assign pipe_pc_d[gi] = pipe_pc_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        inflight = 0;
        if (iss_v_q && iss_f_q) begin
            inflight = 1;
        end
        for (int i = 0; i < MEM_LAT; i++) begin
            if (pipe_v_q[i] && pipe_f_q[i]) begin
                inflight = inflight + 1;
            end
        end
    end

    assign tail_fetch = pipe_v_q[MEM_LAT-1] && pipe_f_q[MEM_LAT-1];
    assign tail_read  = pipe_v_q[MEM_LAT-1] && !pipe_f_q[MEM_LAT-1];
    assign accept     = D_REQ && !d_busy_q;
    assign push       = tail_fetch && !JUMP;
    assign pop        = OP_POP && (count_q != '0) && !JUMP;
    assign fetch_src  = JUMP ? JUMP_PC : fetch_pc_q;
    // Queued plus in-flight fetches never exceed DEPTH, so a push always has room.
    assign credit     = JUMP || ((int'(count_q) + inflight) < DEPTH);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            a_q        <= RESET_PC;
            do_q       <= '0;
            w_q        <= 1'b0;
            fetch_pc_q <= RESET_PC;
            iss_v_q    <= 1'b0;
            iss_f_q    <= 1'b0;
            iss_we_q   <= 1'b0;
            iss_pc_q   <= '0;
        end else begin
            w_q      <= 1'b0;
            iss_v_q  <= 1'b0;
            iss_f_q  <= 1'b0;
            iss_we_q <= 1'b0;
            if (accept) begin
                a_q      <= D_ADDR;
                w_q      <= D_WE;
                iss_v_q  <= 1'b1;
                iss_we_q <= D_WE;
                iss_pc_q <= D_ADDR;
                if (D_WE) begin
                    do_q <= D_WDATA;
                end
                if (JUMP) begin
                    fetch_pc_q <= JUMP_PC;
                end
            end else if (credit) begin
                a_q        <= fetch_src;
                iss_v_q    <= 1'b1;
                iss_f_q    <= 1'b1;
                iss_pc_q   <= fetch_src;
                fetch_pc_q <= fetch_src + AW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pipe_v_q  <= '0;
            pipe_f_q  <= '0;
            pipe_pc_q <= '0;
        end else begin
            pipe_v_q  <= pipe_v_d;
            pipe_f_q  <= pipe_f_d;
            pipe_pc_q <= pipe_pc_d;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (JUMP) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (push) begin
            q_data_mem[tail_q] <= DI;
            q_pc_mem[tail_q]   <= pipe_pc_q[MEM_LAT-1];
        end
    end

    // Writes complete when the W cycle ends; reads when DI is sampled.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            d_busy_q  <= 1'b0;
            d_ack_q   <= 1'b0;
            d_rdata_q <= '0;
        end else begin
            d_ack_q <= 1'b0;
            if (iss_v_q && iss_we_q) begin
                d_ack_q  <= 1'b1;
                d_busy_q <= 1'b0;
            end
            if (tail_read) begin
                d_rdata_q <= DI;
                d_ack_q   <= 1'b1;
                d_busy_q  <= 1'b0;
            end
            if (accept) begin
                d_busy_q <= 1'b1;
            end
        end
    end

    assign A        = a_q;
    assign DO       = do_q;
    assign W        = w_q;
    assign OP_VALID = (count_q != '0);
    assign OP_DATA  = q_data_mem[head_q];
    assign OP_PC    = q_pc_mem[head_q];
    assign D_BUSY   = d_busy_q;
    assign D_ACK    = d_ack_q;
    assign D_RDATA  = d_rdata_q;

endmodule

// File: tb/tb_z80_prefetch_biu.sv
// Directed bench for z80_prefetch_biu: one MEM_LAT=1 instance for prefetch/data/reset
// behaviour and one MEM_LAT=3 instance for jump with fetches in flight.
module tb_z80_prefetch_biu;

    typedef struct packed {
        logic [15:0] pc;
        logic [7:0]  data;
    } op_t;

    logic clk;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] mem [65536];
    op_t        a_sb [$];
    op_t        b_sb [$];
    logic [7:0] rd_sb [$];

    logic        a_rst, a_w, a_jump, a_op_valid, a_pop, a_dreq, a_dwe, a_dbusy, a_dack;
    logic [15:0] a_addr, a_jpc, a_op_pc, a_daddr;
    logic [7:0]  a_di, a_do, a_op_data, a_dwdata, a_drdata;

    logic        b_rst, b_w, b_jump, b_op_valid, b_pop, b_dreq, b_dwe, b_dbusy, b_dack;
    logic [15:0] b_addr, b_jpc, b_op_pc, b_daddr;
    logic [7:0]  b_di, b_do, b_op_data, b_dwdata, b_drdata, b_d1, b_d2;

    z80_prefetch_biu #(.AW(16), .DEPTH(4), .MEM_LAT(1), .RESET_PC(16'h0000)) dut_a (
        .CLOCK(clk), .RESET(a_rst), .A(a_addr), .DI(a_di), .DO(a_do), .W(a_w),
        .JUMP(a_jump), .JUMP_PC(a_jpc), .OP_VALID(a_op_valid), .OP_DATA(a_op_data),
        .OP_PC(a_op_pc), .OP_POP(a_pop), .D_REQ(a_dreq), .D_WE(a_dwe), .D_ADDR(a_daddr),
        .D_WDATA(a_dwdata), .D_BUSY(a_dbusy), .D_ACK(a_dack), .D_RDATA(a_drdata)
    );

    z80_prefetch_biu #(.AW(16), .DEPTH(4), .MEM_LAT(3), .RESET_PC(16'h0000)) dut_b (
        .CLOCK(clk), .RESET(b_rst), .A(b_addr), .DI(b_di), .DO(b_do), .W(b_w),
        .JUMP(b_jump), .JUMP_PC(b_jpc), .OP_VALID(b_op_valid), .OP_DATA(b_op_data),
        .OP_PC(b_op_pc), .OP_POP(b_pop), .D_REQ(b_dreq), .D_WE(b_dwe), .D_ADDR(b_daddr),
        .D_WDATA(b_dwdata), .D_BUSY(b_dbusy), .D_ACK(b_dack), .D_RDATA(b_drdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: latency 1 for instance A, 3 for instance B.
    always @(posedge clk) begin
        a_di <= mem[a_addr];
        b_d1 <= mem[b_addr];
        b_d2 <= b_d1;
        b_di <= b_d2;
        if (a_w) mem[a_addr] = a_do;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compares the A-queue head whenever it is being consumed, then moves one cycle on.
    task automatic advance();
        op_t e;
        if (a_pop && a_op_valid) begin
            e = (a_sb.size() != 0) ? a_sb.pop_front() : '1;
            chk("a_op_pc", 32'(a_op_pc), 32'(e.pc));
            chk("a_op_data", 32'(a_op_data), 32'(e.data));
        end
        tick();
    endtask

    task automatic check_read_ack(input string tag);
        logic [7:0] r;
        r = (rd_sb.size() != 0) ? rd_sb.pop_front() : 8'hxx;
        chk({tag, "_ack"}, 32'(a_dack), 32'd1);
        chk({tag, "_rdata"}, 32'(a_drdata), 32'(r));
    endtask

    initial begin
        op_t e;
        for (int i = 0; i < 65536; i++) mem[i] = i[7:0];
        mem[16'h8000] = 8'h5A;
        a_rst = 1'b1; a_jump = 1'b0; a_jpc = '0; a_pop = 1'b0;
        a_dreq = 1'b0; a_dwe = 1'b0; a_daddr = '0; a_dwdata = '0;
        b_rst = 1'b1; b_jump = 1'b0; b_jpc = '0; b_pop = 1'b0;
        b_dreq = 1'b0; b_dwe = 1'b0; b_daddr = '0; b_dwdata = '0;

        tick(); tick(); tick();
        chk("rst_a", 32'(a_addr), 32'h0);
        chk("rst_w", 32'(a_w), 32'd0);
        chk("rst_do", 32'(a_do), 32'h0);
        chk("rst_op_valid", 32'(a_op_valid), 32'd0);
        chk("rst_busy", 32'(a_dbusy), 32'd0);
        chk("rst_ack", 32'(a_dack), 32'd0);
        chk("rst_rdata", 32'(a_drdata), 32'h0);

        // Prefetch from reset, no pops: A=0,1,2,3 then stall with 4 queued.
        a_rst = 1'b0;
        for (int i = 0; i < 64; i++) a_sb.push_back({16'(i), 8'(i)});
        advance();
        chk("pf_a0", 32'(a_addr), 32'h0);
        chk("pf_valid0", 32'(a_op_valid), 32'd0);
        advance();
        chk("pf_a1", 32'(a_addr), 32'h1);
        chk("pf_valid1", 32'(a_op_valid), 32'd0);
        advance();
        chk("pf_a2", 32'(a_addr), 32'h2);
        chk("pf_valid2", 32'(a_op_valid), 32'd1);
        chk("pf_head_pc", 32'(a_op_pc), 32'h0);
        chk("pf_head_data", 32'(a_op_data), 32'h0);
        advance();
        chk("pf_a3", 32'(a_addr), 32'h3);
        advance(); advance(); advance();
        chk("pf_stall_a", 32'(a_addr), 32'h3);
        chk("pf_stall_w", 32'(a_w), 32'd0);

        // Data read with the queue full.
        a_dreq = 1'b1; a_dwe = 1'b0; a_daddr = 16'h8000;
        rd_sb.push_back(8'h5A);
        advance();
        a_dreq = 1'b0;
        chk("rd_a", 32'(a_addr), 32'h8000);
        chk("rd_busy0", 32'(a_dbusy), 32'd1);
        chk("rd_w", 32'(a_w), 32'd0);
        advance();
        chk("rd_busy1", 32'(a_dbusy), 32'd1);
        chk("rd_noack", 32'(a_dack), 32'd0);
        advance();
        check_read_ack("rd");
        chk("rd_busy_done", 32'(a_dbusy), 32'd0);
        chk("rd_a_hold", 32'(a_addr), 32'h8000);
        chk("rd_q_valid", 32'(a_op_valid), 32'd1);
        chk("rd_q_pc", 32'(a_op_pc), 32'h0);

        // Pop every cycle: no gaps, A steps by one per cycle once refilling.
        a_pop = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("pop_valid", 32'(a_op_valid), 32'd1);
            if (i >= 2) chk("pop_a", 32'(a_addr), 32'(4 + i - 2));
            advance();
        end

        // Write while fetching, then a read accepted in the write's ack cycle.
        a_dreq = 1'b1; a_dwe = 1'b1; a_daddr = 16'h1234; a_dwdata = 8'hC3;
        advance();
        chk("wr_w", 32'(a_w), 32'd1);
        chk("wr_a", 32'(a_addr), 32'h1234);
        chk("wr_do", 32'(a_do), 32'hC3);
        chk("wr_busy", 32'(a_dbusy), 32'd1);
        chk("wr_noack", 32'(a_dack), 32'd0);
        a_dwe = 1'b0;
        rd_sb.push_back(8'hC3);
        advance();
        chk("wr_w_once", 32'(a_w), 32'd0);
        chk("wr_ack", 32'(a_dack), 32'd1);
        chk("wr_busy_ack", 32'(a_dbusy), 32'd0);
        advance();
        a_dreq = 1'b0;
        chk("rb_a", 32'(a_addr), 32'h1234);
        chk("rb_busy", 32'(a_dbusy), 32'd1);
        chk("rb_w", 32'(a_w), 32'd0);
        advance();
        chk("rb_noack", 32'(a_dack), 32'd0);
        advance();
        check_read_ack("rb");
        a_pop = 1'b0;

        // Reset during an outstanding read drops it.
        a_dreq = 1'b1; a_dwe = 1'b0; a_daddr = 16'h8000;
        advance();
        a_dreq = 1'b0;
        chk("rr_a", 32'(a_addr), 32'h8000);
        chk("rr_busy", 32'(a_dbusy), 32'd1);
        a_rst = 1'b1;
        advance();
        a_rst = 1'b0;
        a_sb.delete();
        chk("rr_a_reset", 32'(a_addr), 32'h0);
        chk("rr_valid", 32'(a_op_valid), 32'd0);
        chk("rr_busy_clr", 32'(a_dbusy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("rr_noack", 32'(a_dack), 32'd0);
            advance();
        end

        // MEM_LAT=3: jump to FFFE with two fetches in flight.
        b_rst = 1'b0;
        tick();
        chk("j_a0", 32'(b_addr), 32'h0);
        tick();
        chk("j_a1", 32'(b_addr), 32'h1);
        b_jump = 1'b1; b_jpc = 16'hFFFE;
        b_sb.push_back({16'hFFFE, 8'hFE});
        b_sb.push_back({16'hFFFF, 8'hFF});
        b_sb.push_back({16'h0000, 8'h00});
        b_sb.push_back({16'h0001, 8'h01});
        tick();
        b_jump = 1'b0;
        chk("j_a_target", 32'(b_addr), 32'hFFFE);
        chk("j_valid2", 32'(b_op_valid), 32'd0);
        b_pop = 1'b1;
        for (int i = 3; i <= 14; i++) begin
            tick();
            if (i <= 5) chk("j_stale_valid", 32'(b_op_valid), 32'd0);
            if (i == 6) chk("j_first_valid", 32'(b_op_valid), 32'd1);
            if (i == 3) chk("j_a_ffff", 32'(b_addr), 32'hFFFF);
            if (i == 4) chk("j_a_wrap", 32'(b_addr), 32'h0000);
            if (b_op_valid && b_sb.size() != 0) begin
                e = b_sb.pop_front();
                chk("j_op_pc", 32'(b_op_pc), 32'(e.pc));
                chk("j_op_data", 32'(b_op_data), 32'(e.data));
            end
        end
        b_pop = 1'b0;

        chk("rd_sb_drained", 32'(rd_sb.size()), 32'd0);
        chk("j_sb_drained", 32'(b_sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
